// File: rtl/riscv_32_fetch_stage.sv
// ---------------------------------------------------------------------------
// riscv_32_fetch_stage
//
// Instruction fetch stage of the 3-stage RV32 CPU, feeding
// riscv_32_instr_decoder. It owns the PC, issues one word read at a time to
// a variable-latency instruction memory, and holds the fetched word on a
// valid/ready interface to decode. Redirects from execute change the PC and
// squash any in-flight or held wrong-path instruction.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous, active-high reset
//   imem_req        read request; memory samples imem_addr when high
//   imem_addr       word address = pc[IMEM_AW+1:2]
//   imem_rvalid     read data valid (>=1 cycle after req, once per req)
//   imem_rdata      instruction word from memory
//   instr_valid     instr / instr_pc / instr_pc4 hold a valid instruction
//   instr_ready     decode accepts (low = stall)
//   instr           instruction word to decode
//   instr_pc        PC of instr
//   instr_pc4       instr_pc + 4 (link value for JAL/JALR)
//   redirect_valid  execute redirects fetch this cycle
//   redirect_pc     redirect target; bits [1:0] are forced to 0
//   fetch_pc        current PC register (debug display)
// ---------------------------------------------------------------------------
module riscv_32_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 12
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        instr,
  output logic [31:0]        instr_pc,
  output logic [31:0]        instr_pc4,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [31:0]        fetch_pc
);

  localparam logic [31:0] NOP = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    S_FETCH,  // request issued this cycle
    S_WAIT,   // request outstanding, data wanted
    S_HOLD,   // instruction presented to decode
    S_DROP    // request outstanding, data is wrong-path
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  // 32-bit modulo increment: 32'hFFFF_FFFC wraps to zero by design.
  assign pc_plus4 = pc + 32'd4;

  // NOTE: the request is a Moore output of the state register, but reset
  // leaves the state in S_FETCH, so it is masked while rst is high to keep
  // the memory from seeing a request during the reset cycle itself.
  assign imem_req  = (state == S_FETCH) && !rst;
  // Truncation to IMEM_AW word bits is intended (aliasing above memory size).
  assign imem_addr = pc[IMEM_AW+1:2];
  assign fetch_pc  = pc;

  // NOTE: every register here is sequential state, so all updates use
  // non-blocking assignments and the reset branch is sampled on the clock
  // edge rather than listed in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= NOP;
      instr_pc    <= 32'h0;
      instr_pc4   <= 32'h0;
    end else if (redirect_valid) begin
      // Redirect wins over everything, including a same-cycle handshake.
      pc          <= redirect_pc & ~32'h3;
      instr_valid <= 1'b0;
      case (state)
        // The request issued this cycle still has to be drained.
        S_FETCH: state <= S_DROP;
        // Outstanding request: drain unless its data is arriving right now.
        S_WAIT,
        S_DROP:  state <= imem_rvalid ? S_FETCH : S_DROP;
        default: state <= S_FETCH;
      endcase
    end else begin
      case (state)
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_pc4   <= pc_plus4;
            pc          <= pc_plus4;
            instr_valid <= 1'b1;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= S_FETCH;
          end
        end
        default: begin
          if (imem_rvalid) state <= S_FETCH;
        end
      endcase
    end
  end

endmodule
